// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32I opcode, branch-counter constants and B-immediate decode
package riscv_pkg;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    function automatic logic signed [31:0] imm_b(input logic [31:0] inst);
        return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    endfunction

endpackage

// File: rtl/bht_2bit.sv
// rtl/bht_2bit.sv - bimodal table of 2-bit saturating counters, falling-edge updated
module bht_2bit
    import riscv_pkg::*;
#(
    parameter int BHT_ENTRIES = 16,
    localparam int IDX_W = $clog2(BHT_ENTRIES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_taken,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_taken
);

    logic [1:0] ctr_q [BHT_ENTRIES];
    logic [1:0] ctr_d;

    // Read is combinational from the registered array, so a same-cycle write is seen next edge.
    assign rd_taken = ctr_q[rd_idx][1];

    always_comb begin
        ctr_d = ctr_q[wr_idx];
        if (wr_taken) begin
            if (ctr_q[wr_idx] != ST) ctr_d = ctr_q[wr_idx] + 2'd1;
        end else begin
            if (ctr_q[wr_idx] != SNT) ctr_d = ctr_q[wr_idx] - 2'd1;
        end
    end

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                ctr_q[i] <= WNT;
            end
        end else if (wr_en) begin
            ctr_q[wr_idx] <= ctr_d;
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - RV32I fetch stage: PC, next-PC select, optional bimodal prediction
// Define IF_BHT_PRED_EN to enable the BHT; otherwise fetch is static not-taken.
module if_fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          BHT_ENTRIES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic [31:0] pc,
    output logic        guess
);

    localparam int BHT_IDX_W = $clog2(BHT_ENTRIES);

    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] tgt;

    assign imem_addr = pc_q;
    assign inst      = imem_rdata;
    assign pc        = pc_q;

`ifdef IF_BHT_PRED_EN
    logic is_br;
    logic bht_taken;

    assign is_br = (imem_rdata[6:0] == OPC_BRANCH);
    assign tgt   = pc_q + imm_b(imem_rdata);
    assign guess = is_br & bht_taken;

    bht_2bit #(
        .BHT_ENTRIES(BHT_ENTRIES)
    ) u_bht (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (pc_q[BHT_IDX_W+1:2]),
        .rd_taken (bht_taken),
        .wr_en    (upd_valid),
        .wr_idx   (upd_pc[BHT_IDX_W+1:2]),
        .wr_taken (upd_taken)
    );

    logic unused_upd_bits;
    assign unused_upd_bits = &{1'b0, upd_pc[31:BHT_IDX_W+2], upd_pc[1:0]};
`else
    assign tgt   = pc_q + 32'd4;
    assign guess = 1'b0;

    logic unused_upd;
    assign unused_upd = &{1'b0, upd_valid, upd_pc, upd_taken};
`endif

    // Redirect outranks stall: EX has already resolved the path and flushes downstream itself.
    always_comb begin
        if (redirect) begin
            pc_d = redirect_pc;
        end else if (stall) begin
            pc_d = pc_q;
        end else if (guess) begin
            pc_d = tgt;
        end else begin
            pc_d = pc_q + 32'd4;
        end
    end

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb/tb_if_fetch_stage.sv - scoreboard bench for if_fetch_stage (either IF_BHT_PRED_EN build)
module tb_if_fetch_stage;

`ifdef IF_BHT_PRED_EN
    localparam bit PRED = 1'b1;
`else
    localparam bit PRED = 1'b0;
`endif

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] BEQ_P20 = 32'h0200_0063;

    typedef struct packed {
        logic [31:0] pc;
        logic        guess;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        guess;

    logic [31:0] mem [256];
    exp_t        exp_q [$];
    int          checks = 0;
    int          failures = 0;

    if_fetch_stage #(
        .RESET_PC   (32'h0000_0000),
        .BHT_ENTRIES(16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .upd_valid  (upd_valid),
        .upd_pc     (upd_pc),
        .upd_taken  (upd_taken),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .inst       (inst),
        .pc         (pc),
        .guess      (guess)
    );

    assign imem_rdata = mem[imem_addr[9:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: state changes on the falling edge, so sample on the rising edge.
    always @(posedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("pc", pc, e.pc);
            chk("imem_addr", imem_addr, e.pc);
            chk("guess", {31'd0, guess}, {31'd0, e.guess});
            chk("inst", inst, mem[e.pc[9:2]]);
        end
    end

    task automatic cyc(input logic st, input logic rd, input logic [31:0] rpc,
                       input logic uv, input logic [31:0] up, input logic ut,
                       input logic [31:0] epc, input logic eg);
        exp_t e;
        @(posedge clk);
        #1;
        stall = st; redirect = rd; redirect_pc = rpc;
        upd_valid = uv; upd_pc = up; upd_taken = ut;
        e.pc = epc;
        e.guess = eg;
        exp_q.push_back(e);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = NOP;
        mem[4]  = BEQ_P20;
        mem[19] = BEQ_P20;
        rst = 1'b0;
        stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
        upd_valid = 1'b0; upd_pc = 32'd0; upd_taken = 1'b0;

        #1;
        chk("reset_pc", pc, 32'h0);
        chk("reset_guess", {31'd0, guess}, 32'd0);
        rst = 1'b1;

        // Sequential NOP fetch
        cyc(0, 0, 0, 0, 0, 0, 32'h04, 0);
        cyc(0, 0, 0, 0, 0, 0, 32'h08, 0);
        cyc(0, 0, 0, 0, 0, 0, 32'h0C, 0);
        cyc(0, 0, 0, 0, 0, 0, 32'h10, 0);
        // Branch at 0x10 with reset counter: not taken
        cyc(0, 0, 0, 0, 0, 0, 32'h14, 0);
        cyc(0, 0, 0, 1, 32'h10, 1, 32'h18, 0);
        cyc(0, 0, 0, 1, 32'h10, 1, 32'h1C, 0);
        cyc(0, 1, 32'h10, 0, 0, 0, 32'h10, PRED);
        cyc(0, 0, 0, 0, 0, 0, PRED ? 32'h30 : 32'h14, 0);

        // Stall hold, then redirect beats stall
        cyc(0, 1, 32'h40, 0, 0, 0, 32'h40, 0);
        cyc(1, 0, 0, 0, 0, 0, 32'h40, 0);
        cyc(1, 0, 0, 0, 0, 0, 32'h40, 0);
        cyc(1, 0, 0, 0, 0, 0, 32'h40, 0);
        cyc(1, 1, 32'h100, 0, 0, 0, 32'h100, 0);

        // Saturation on index 3 (pc 0x4C), updates independent of stall/redirect
        for (int i = 0; i < 5; i++) cyc(1, 0, 0, 1, 32'h4C, 1, 32'h100, 0);
        cyc(0, 1, 32'h4C, 1, 32'h4C, 0, 32'h4C, PRED);
        cyc(1, 0, 0, 1, 32'h4C, 0, 32'h4C, 0);
        cyc(1, 0, 0, 1, 32'h4C, 0, 32'h4C, 0);
        cyc(1, 0, 0, 1, 32'h4C, 0, 32'h4C, 0);
        cyc(1, 0, 0, 1, 32'h4C, 1, 32'h4C, 0);
        cyc(1, 0, 0, 1, 32'h4C, 1, 32'h4C, PRED);
        cyc(0, 0, 0, 0, 0, 0, PRED ? 32'h6C : 32'h50, 0);

        // Wrap and misaligned redirect
        cyc(0, 1, 32'hFFFF_FFFC, 0, 0, 0, 32'hFFFF_FFFC, 0);
        cyc(0, 0, 0, 0, 0, 0, 32'h0000_0000, 0);
        cyc(0, 1, 32'h202, 0, 0, 0, 32'h202, 0);
        cyc(0, 0, 0, 0, 0, 0, 32'h206, 0);

        // Async reset between edges
        cyc(0, 1, 32'h80, 0, 0, 0, 32'h80, 0);
        @(posedge clk);
        #1;
        redirect = 1'b0;
        #1;
        rst = 1'b0;
        #1;
        chk("async_reset_pc", pc, 32'h0);
        chk("async_reset_addr", imem_addr, 32'h0);
        @(negedge clk);
        #1;
        chk("held_reset_pc", pc, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Counters must be back at weakly not-taken
        cyc(0, 1, 32'h10, 0, 0, 0, 32'h10, 0);
        cyc(0, 1, 32'h4C, 0, 0, 0, 32'h4C, 0);
        cyc(1, 0, 0, 1, 32'h4C, 1, 32'h4C, PRED);
        cyc(0, 0, 0, 0, 0, 0, PRED ? 32'h6C : 32'h50, 0);

        @(posedge clk);
        #1;
        stall = 1'b0; redirect = 1'b0; upd_valid = 1'b0;
        @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain actual=%0d required=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
